// File: rtl/natv_arbiter.sv
// Two-master round-robin arbiter for the shared natv peripheral slave.
// Optional watchdog completion is compiled in with `define NATV_ARB_TIMEOUT_EN.
module natv_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        m0_valid_i,
  input  logic [31:0] m0_addr_i,
  input  logic [31:0] m0_wdata_i,
  input  logic [3:0]  m0_wstrb_i,
  output logic [31:0] m0_rdata_o,
  output logic        m0_ready_o,
  input  logic        m1_valid_i,
  input  logic [31:0] m1_addr_i,
  input  logic [31:0] m1_wdata_i,
  input  logic [3:0]  m1_wstrb_i,
  output logic [31:0] m1_rdata_o,
  output logic        m1_ready_o,
  output logic        s_valid_o,
  output logic [31:0] s_addr_o,
  output logic [31:0] s_wdata_o,
  output logic [3:0]  s_wstrb_o,
  input  logic [31:0] s_rdata_i,
  input  logic        s_ready_i,
  output logic [1:0]  grant_o,
  input  logic        err_clr_i,
  output logic        timeout_err_o,
  output logic        state_o
);

  // Handshake: a master holds valid and its fields until its ready pulses for
  // one cycle; the slave sees s_valid_o held with constant fields until s_ready_i.
  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t      state_q, state_d;
  logic [1:0]  grant_q, grant_d;
  logic        last_q, last_d;
  logic [31:0] addr_q, wdata_q;
  logic [3:0]  wstrb_q;
  logic        load, pick_m1, done, to_hit;
  logic [31:0] rdata_mux;

  assign rdata_mux = s_ready_i ? s_rdata_i : 32'hFFFF_FFFF;

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    last_d     = last_q;
    load       = 1'b0;
    pick_m1    = 1'b0;
    done       = 1'b0;
    m0_ready_o = 1'b0;
    m1_ready_o = 1'b0;
    m0_rdata_o = 32'h0;
    m1_rdata_o = 32'h0;
    case (state_q)
      IDLE: begin
        if (m0_valid_i || m1_valid_i) begin
          // last_q set means m1 was served last, so m0 wins a tie
          pick_m1 = m1_valid_i && (!m0_valid_i || !last_q);
          load    = 1'b1;
          grant_d = pick_m1 ? 2'b10 : 2'b01;
          state_d = BUSY;
        end
      end
      BUSY: begin
        done = s_ready_i || to_hit;
        if (done) begin
          state_d    = IDLE;
          grant_d    = 2'b00;
          last_d     = grant_q[1];
          m0_ready_o = grant_q[0];
          m1_ready_o = grant_q[1];
          m0_rdata_o = grant_q[0] ? rdata_mux : 32'h0;
          m1_rdata_o = grant_q[1] ? rdata_mux : 32'h0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      grant_q <= 2'b00;
      last_q  <= 1'b1;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      wstrb_q <= 4'h0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      if (load) begin
        addr_q  <= pick_m1 ? m1_addr_i  : m0_addr_i;
        wdata_q <= pick_m1 ? m1_wdata_i : m0_wdata_i;
        wstrb_q <= pick_m1 ? m1_wstrb_i : m0_wstrb_i;
      end
    end
  end

`ifdef NATV_ARB_TIMEOUT_EN
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] cnt_q;
  logic        err_q;

  assign to_hit = (state_q == BUSY) && !s_ready_i && (cnt_q == TO_LAST);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= 16'h0;
      err_q <= 1'b0;
    end else begin
      if (load) begin
        cnt_q <= 16'h0;
      end else if ((state_q == BUSY) && !s_ready_i && !to_hit) begin
        cnt_q <= cnt_q + 16'h1;
      end
      // a timeout in the same cycle as a clear keeps the flag set
      if (to_hit) begin
        err_q <= 1'b1;
      end else if (err_clr_i) begin
        err_q <= 1'b0;
      end
    end
  end

  assign timeout_err_o = err_q;
`else
  logic unused_cfg;

  assign to_hit        = 1'b0;
  assign timeout_err_o = 1'b0;
  assign unused_cfg    = err_clr_i ^ (TIMEOUT_CYCLES == 0);
`endif

  assign s_valid_o = (state_q == BUSY);
  assign s_addr_o  = addr_q;
  assign s_wdata_o = wdata_q;
  assign s_wstrb_o = wstrb_q;
  assign grant_o   = grant_q;
  assign state_o   = (state_q == BUSY);

endmodule

// File: tb/tb_natv_arbiter.sv
// Directed bench for natv_arbiter; timeout section follows NATV_ARB_TIMEOUT_EN.
module tb_natv_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        m0_valid_i, m1_valid_i;
  logic [31:0] m0_addr_i, m0_wdata_i, m1_addr_i, m1_wdata_i;
  logic [3:0]  m0_wstrb_i, m1_wstrb_i;
  logic [31:0] m0_rdata_o, m1_rdata_o;
  logic        m0_ready_o, m1_ready_o;
  logic        s_valid_o;
  logic [31:0] s_addr_o, s_wdata_o;
  logic [3:0]  s_wstrb_o;
  logic [31:0] s_rdata_i;
  logic        s_ready_i;
  logic [1:0]  grant_o;
  logic        err_clr_i;
  logic        timeout_err_o;
  logic        state_o;

  int n_total = 0;
  int n_bad   = 0;

  natv_arbiter #(.TIMEOUT_CYCLES(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .m0_valid_i(m0_valid_i), .m0_addr_i(m0_addr_i), .m0_wdata_i(m0_wdata_i),
    .m0_wstrb_i(m0_wstrb_i), .m0_rdata_o(m0_rdata_o), .m0_ready_o(m0_ready_o),
    .m1_valid_i(m1_valid_i), .m1_addr_i(m1_addr_i), .m1_wdata_i(m1_wdata_i),
    .m1_wstrb_i(m1_wstrb_i), .m1_rdata_o(m1_rdata_o), .m1_ready_o(m1_ready_o),
    .s_valid_o(s_valid_o), .s_addr_o(s_addr_o), .s_wdata_o(s_wdata_o),
    .s_wstrb_o(s_wstrb_o), .s_rdata_i(s_rdata_i), .s_ready_i(s_ready_i),
    .grant_o(grant_o), .err_clr_i(err_clr_i), .timeout_err_o(timeout_err_o),
    .state_o(state_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_svalid"}, 32'(s_valid_o), 32'h0);
    chk({tag, "_grant"}, 32'(grant_o), 32'h0);
    chk({tag, "_m0rdy"}, 32'(m0_ready_o), 32'h0);
    chk({tag, "_m1rdy"}, 32'(m1_ready_o), 32'h0);
  endtask

  initial begin
    rst_i = 1'b1;
    m0_valid_i = 1'b0; m0_addr_i = '0; m0_wdata_i = '0; m0_wstrb_i = '0;
    m1_valid_i = 1'b0; m1_addr_i = '0; m1_wdata_i = '0; m1_wstrb_i = '0;
    s_rdata_i = '0; s_ready_i = 1'b0; err_clr_i = 1'b0;

    // reset state
    cyc(); cyc();
    #1;
    chk_idle("rst");
    chk("rst_addr", s_addr_o, 32'h0);
    chk("rst_wdata", s_wdata_o, 32'h0);
    chk("rst_wstrb", 32'(s_wstrb_o), 32'h0);
    chk("rst_m0rdata", m0_rdata_o, 32'h0);
    chk("rst_m1rdata", m1_rdata_o, 32'h0);
    chk("rst_err", 32'(timeout_err_o), 32'h0);
    chk("rst_state", 32'(state_o), 32'h0);

    // single m0 read, slave ready two cycles after s_valid_o
    cyc(); rst_i = 1'b0;
    cyc(); m0_valid_i = 1'b1; m0_addr_i = 32'h1000; m0_wstrb_i = 4'h0; #1;
    chk("rd_t0_svalid", 32'(s_valid_o), 32'h0);
    cyc(); #1;
    chk("rd_t1_svalid", 32'(s_valid_o), 32'h1);
    chk("rd_t1_grant", 32'(grant_o), 32'h1);
    chk("rd_t1_addr", s_addr_o, 32'h1000);
    chk("rd_t1_m0rdy", 32'(m0_ready_o), 32'h0);
    cyc(); #1;
    chk("rd_t2_m0rdy", 32'(m0_ready_o), 32'h0);
    cyc(); s_ready_i = 1'b1; s_rdata_i = 32'hCAFE_BABE; #1;
    chk("rd_t3_m0rdy", 32'(m0_ready_o), 32'h1);
    chk("rd_t3_m0rdata", m0_rdata_o, 32'hCAFE_BABE);
    chk("rd_t3_m1rdy", 32'(m1_ready_o), 32'h0);
    chk("rd_t3_m1rdata", m1_rdata_o, 32'h0);
    cyc(); s_ready_i = 1'b0; m0_valid_i = 1'b0; #1;
    chk_idle("rd_t4");

    // contention right after reset: m0 first, one idle cycle, then m1
    rst_i = 1'b1;
    cyc(); rst_i = 1'b0;
    m0_valid_i = 1'b1; m0_addr_i = 32'h100;
    m1_valid_i = 1'b1; m1_addr_i = 32'h200;
    cyc(); s_ready_i = 1'b1; s_rdata_i = 32'h1111_0000; #1;
    chk("ct_grant0", 32'(grant_o), 32'h1);
    chk("ct_addr0", s_addr_o, 32'h100);
    chk("ct_m0rdy", 32'(m0_ready_o), 32'h1);
    chk("ct_m1rdy0", 32'(m1_ready_o), 32'h0);
    cyc(); s_ready_i = 1'b0; m0_valid_i = 1'b0; #1;
    chk_idle("ct_gap");
    cyc(); s_ready_i = 1'b1; s_rdata_i = 32'h2222_0000; #1;
    chk("ct_grant1", 32'(grant_o), 32'h2);
    chk("ct_addr1", s_addr_o, 32'h200);
    chk("ct_m1rdy", 32'(m1_ready_o), 32'h1);
    chk("ct_m1rdata", m1_rdata_o, 32'h2222_0000);
    chk("ct_m0rdata", m0_rdata_o, 32'h0);
    cyc(); s_ready_i = 1'b0; m1_valid_i = 1'b0; #1;
    chk_idle("ct_end");

    // continuous requests from both: grants 01,10,01,10
    m0_valid_i = 1'b1; m1_valid_i = 1'b1;
    cyc(); s_ready_i = 1'b1; #1;
    chk("rr0_grant", 32'(grant_o), 32'h1);
    chk("rr0_m0rdy", 32'(m0_ready_o), 32'h1);
    cyc(); s_ready_i = 1'b0; #1;
    chk("rr0_gap", 32'(s_valid_o), 32'h0);
    cyc(); s_ready_i = 1'b1; #1;
    chk("rr1_grant", 32'(grant_o), 32'h2);
    chk("rr1_m1rdy", 32'(m1_ready_o), 32'h1);
    cyc(); s_ready_i = 1'b0; #1;
    chk("rr1_gap", 32'(s_valid_o), 32'h0);
    cyc(); s_ready_i = 1'b1; #1;
    chk("rr2_grant", 32'(grant_o), 32'h1);
    cyc(); s_ready_i = 1'b0; #1;
    cyc(); s_ready_i = 1'b1; #1;
    chk("rr3_grant", 32'(grant_o), 32'h2);
    cyc(); s_ready_i = 1'b0; m0_valid_i = 1'b0; m1_valid_i = 1'b0; #1;
    chk_idle("rr_end");

    // m1 write; changing master fields mid-transaction must not leak
    m1_valid_i = 1'b1; m1_addr_i = 32'h4000; m1_wdata_i = 32'h1F; m1_wstrb_i = 4'b0001;
    cyc(); m1_addr_i = 32'h5000; m1_wdata_i = 32'hAA; m1_wstrb_i = 4'hF; #1;
    chk("wr_grant", 32'(grant_o), 32'h2);
    chk("wr_addr0", s_addr_o, 32'h4000);
    chk("wr_wdata0", s_wdata_o, 32'h1F);
    chk("wr_wstrb0", 32'(s_wstrb_o), 32'h1);
    cyc(); #1;
    chk("wr_addr1", s_addr_o, 32'h4000);
    chk("wr_wstrb1", 32'(s_wstrb_o), 32'h1);
    cyc(); s_ready_i = 1'b1; #1;
    chk("wr_addr2", s_addr_o, 32'h4000);
    chk("wr_wdata2", s_wdata_o, 32'h1F);
    chk("wr_m1rdy", 32'(m1_ready_o), 32'h1);
    chk("wr_m0rdy", 32'(m0_ready_o), 32'h0);
    cyc(); s_ready_i = 1'b0; m1_valid_i = 1'b0; #1;
    chk_idle("wr_end");

`ifdef NATV_ARB_TIMEOUT_EN
    // slave never ready: forced completion on the fourth BUSY cycle
    m0_valid_i = 1'b1; m0_addr_i = 32'h8000; s_rdata_i = 32'h1234_5678;
    cyc(); #1;
    chk("to_c1_rdy", 32'(m0_ready_o), 32'h0);
    cyc(); #1;
    chk("to_c2_rdy", 32'(m0_ready_o), 32'h0);
    cyc(); #1;
    chk("to_c3_rdy", 32'(m0_ready_o), 32'h0);
    cyc(); #1;
    chk("to_c4_rdy", 32'(m0_ready_o), 32'h1);
    chk("to_c4_rdata", m0_rdata_o, 32'hFFFF_FFFF);
    chk("to_c4_err", 32'(timeout_err_o), 32'h0);
    cyc(); m0_valid_i = 1'b0; #1;
    chk("to_err_set", 32'(timeout_err_o), 32'h1);
    chk("to_idle", 32'(s_valid_o), 32'h0);
    err_clr_i = 1'b1;
    cyc(); err_clr_i = 1'b0; #1;
    chk("to_err_clr", 32'(timeout_err_o), 32'h0);
    // slave ready on the timeout cycle: normal completion, no error
    m1_valid_i = 1'b1; m1_addr_i = 32'h9000;
    cyc(); cyc(); cyc(); cyc(); s_ready_i = 1'b1; #1;
    chk("tr_m1rdy", 32'(m1_ready_o), 32'h1);
    chk("tr_m1rdata", m1_rdata_o, 32'h1234_5678);
    cyc(); s_ready_i = 1'b0; m1_valid_i = 1'b0; #1;
    chk("tr_err", 32'(timeout_err_o), 32'h0);
    chk_idle("tr_end");
`else
    // no watchdog: BUSY holds indefinitely and the flag stays low
    m0_valid_i = 1'b1; m0_addr_i = 32'h8000;
    for (int i = 0; i < 8; i++) begin
      cyc(); err_clr_i = (i == 3); #1;
      chk("nt_svalid", 32'(s_valid_o), 32'h1);
      chk("nt_m0rdy", 32'(m0_ready_o), 32'h0);
      chk("nt_err", 32'(timeout_err_o), 32'h0);
    end
    cyc(); err_clr_i = 1'b0; s_ready_i = 1'b1; s_rdata_i = 32'h0BAD_F00D; #1;
    chk("nt_done_rdy", 32'(m0_ready_o), 32'h1);
    chk("nt_done_rdata", m0_rdata_o, 32'h0BAD_F00D);
    cyc(); s_ready_i = 1'b0; m0_valid_i = 1'b0; #1;
    chk_idle("nt_end");
`endif

    // reset mid-transaction aborts with no ready pulse
    m1_valid_i = 1'b1; m1_addr_i = 32'hA000; m1_wdata_i = 32'h55; m1_wstrb_i = 4'h3;
    cyc(); #1;
    chk("ab_busy", 32'(s_valid_o), 32'h1);
    rst_i = 1'b1; #1;
    chk("ab_m1rdy_rst", 32'(m1_ready_o), 32'h0);
    cyc(); rst_i = 1'b0; m1_valid_i = 1'b0; #1;
    chk_idle("ab_after");
    chk("ab_addr", s_addr_o, 32'h0);
    chk("ab_wdata", s_wdata_o, 32'h0);
    chk("ab_wstrb", 32'(s_wstrb_o), 32'h0);
    chk("ab_err", 32'(timeout_err_o), 32'h0);
    chk("ab_state", 32'(state_o), 32'h0);
    cyc(); #1;
    chk_idle("ab_hold");

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
